// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch unit with redirect and drain
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;

    // Request and address depend on state only, so the memory sees a clean pulse.
    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;

    // State and datapath registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Next-state logic; a redirect overrides every other event in the same cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        if (redirect_valid) begin
            pc_d         = redirect_pc & 32'hFFFF_FFFC;
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
            case (state_q)
                S_IDLE, S_HOLD: state_d = S_REQ;
                // The request issued this cycle is already in flight.
                S_REQ:          state_d = S_DRAIN;
                // A response landing now is discarded; otherwise wait it out.
                S_WAIT, S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default:        state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ:  state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        inst_d       = imem_rdata;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                        state_d      = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (inst_valid_q && inst_ready) begin
                        inst_valid_d = 1'b0;
                        inst_d       = NOP_INST;
                        state_d      = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] inst, inst2;
    logic [31:0] inst_pc, inst_pc2;
    logic        inst_valid, inst_valid2;

    int checks;
    int errors;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst(inst2), .inst_pc(inst_pc2), .inst_valid(inst_valid2),
        .inst_ready(inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] inst;
        logic [31:0] ipc;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rv, input logic [31:0] rd, input logic redir,
                                input logic [31:0] rpc, input logic rdy, input logic req,
                                input logic [31:0] addr, input logic iv,
                                input logic [31:0] ins, input logic [31:0] ipc);
        vec_t v;
        v.rv = rv; v.rd = rd; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.req = req; v.addr = addr; v.iv = iv; v.inst = ins; v.ipc = ipc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b0;

        //           rv  rd            redir rpc           rdy req addr          iv inst          ipc
        vecs[0]  = mk(0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, NOP,          32'h0);   // IDLE
        vecs[1]  = mk(0, 32'h0,        0, 32'h0,        1, 1, 32'h0,        0, NOP,          32'h0);   // REQ @0
        vecs[2]  = mk(1, 32'h00500093, 0, 32'h0,        1, 0, 32'h0,        0, NOP,          32'h0);   // WAIT, resp
        vecs[3]  = mk(0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h00500093, 32'h0);   // HOLD, hs
        vecs[4]  = mk(0, 32'h0,        0, 32'h0,        1, 1, 32'h4,        0, NOP,          32'h0);   // REQ @4
        vecs[5]  = mk(1, 32'h11111111, 0, 32'h0,        0, 0, 32'h0,        0, NOP,          32'h0);   // WAIT, resp
        vecs[6]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h11111111, 32'h4);   // HOLD stall
        vecs[7]  = mk(1, 32'hCAFECAFE, 0, 32'h0,        0, 0, 32'h0,        1, 32'h11111111, 32'h4);   // stray rvalid
        vecs[8]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h11111111, 32'h4);
        vecs[9]  = mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h11111111, 32'h4);
        vecs[10] = mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h11111111, 32'h4);
        vecs[11] = mk(0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h11111111, 32'h4);   // hs
        vecs[12] = mk(0, 32'h0,        0, 32'h0,        0, 1, 32'h8,        0, NOP,          32'h4);   // REQ @8
        vecs[13] = mk(0, 32'h0,        1, 32'h00000103, 0, 0, 32'h0,        0, NOP,          32'h4);   // WAIT redirect
        vecs[14] = mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, NOP,          32'h4);   // DRAIN
        vecs[15] = mk(1, 32'hDEADBEEF, 0, 32'h0,        0, 0, 32'h0,        0, NOP,          32'h4);   // DRAIN resp dropped
        vecs[16] = mk(0, 32'h0,        0, 32'h0,        0, 1, 32'h100,      0, NOP,          32'h4);   // REQ @100
        vecs[17] = mk(1, 32'hBADBADBA, 1, 32'h200,      0, 0, 32'h0,        0, NOP,          32'h4);   // WAIT redir+rvalid
        vecs[18] = mk(0, 32'h0,        0, 32'h0,        0, 1, 32'h200,      0, NOP,          32'h4);   // REQ @200
        vecs[19] = mk(1, 32'h22222222, 0, 32'h0,        0, 0, 32'h0,        0, NOP,          32'h4);   // WAIT resp
        vecs[20] = mk(0, 32'h0,        1, 32'h300,      1, 0, 32'h0,        1, 32'h22222222, 32'h200); // HOLD redir+hs
        vecs[21] = mk(0, 32'h0,        1, 32'h407,      0, 1, 32'h300,      0, NOP,          32'h200); // REQ redirect
        vecs[22] = mk(0, 32'h0,        1, 32'h500,      0, 0, 32'h0,        0, NOP,          32'h200); // DRAIN redirect
        vecs[23] = mk(1, 32'h44444444, 1, 32'h600,      0, 0, 32'h0,        0, NOP,          32'h200); // DRAIN redir+rvalid
        vecs[24] = mk(0, 32'h0,        0, 32'h0,        0, 1, 32'h600,      0, NOP,          32'h200); // REQ @600
        vecs[25] = mk(0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, NOP,          32'h200); // WAIT no resp
        vecs[26] = mk(1, 32'h33333333, 0, 32'h0,        1, 0, 32'h0,        0, NOP,          32'h200); // WAIT resp
        vecs[27] = mk(0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h33333333, 32'h600); // HOLD hs
        vecs[28] = mk(0, 32'h0,        0, 32'h0,        0, 1, 32'h604,      0, NOP,          32'h600); // REQ @604

        // Reset values, held with the clock running.
        repeat (2) @(negedge clk);
        #1;
        check("reset_req", {31'h0, imem_req}, 32'h0);
        check("reset_valid", {31'h0, inst_valid}, 32'h0);
        check("reset_inst", inst, NOP);
        check("reset_inst_pc", inst_pc, 32'h0);
        check("reset_pc", imem_addr, 32'h0);
        check("reset_pc_wrap", imem_addr2, 32'hFFFF_FFFC);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            if (i > 0) @(negedge clk);
            imem_rvalid    = vecs[i].rv;
            imem_rdata     = vecs[i].rd;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            inst_ready     = vecs[i].rdy;
            #1;
            check($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].req});
            if (vecs[i].req) check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("v%0d_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].iv});
            check($sformatf("v%0d_inst", i), inst, vecs[i].inst);
            check($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].ipc);
            // The wrap instance follows the same state sequence from 0xFFFFFFFC.
            if (i == 1) check("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);
            if (i == 3) check("wrap_inst_pc", inst_pc2, 32'hFFFF_FFFC);
            if (i == 3) check("wrap_valid", {31'h0, inst_valid2}, 32'h1);
            if (i == 4) check("wrap_next_addr", imem_addr2, 32'h0);
            if (i == 4) check("wrap_next_req", {31'h0, imem_req2}, 32'h1);
        end

        // Reset pulsed in WAIT: effect is immediate, stray response after release is ignored.
        @(negedge clk);
        imem_rvalid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        #1;
        check("wait_before_reset_req", {31'h0, imem_req}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_inst_pc", inst_pc, 32'h0);
        check("async_reset_valid", {31'h0, inst_valid}, 32'h0);
        check("async_reset_pc", imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hFEEDFACE;
        #1;
        check("idle_after_reset_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        check("restart_req", {31'h0, imem_req}, 32'h1);
        check("restart_addr", imem_addr, 32'h0);
        check("restart_valid", {31'h0, inst_valid}, 32'h0);
        check("restart_inst", inst, NOP);
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h55555555;
        #1;
        check("restart_wait_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        check("restart_valid_hold", {31'h0, inst_valid}, 32'h1);
        check("restart_inst_hold", inst, 32'h55555555);
        check("restart_inst_pc_hold", inst_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
